test_ram_master: RTL and testbench

- Bus initiator that drives the test_ram responder port (we/addr/data_in in, data_out/data_ready back).
- Accepts byte or 16-bit little-endian read/write requests from the CPU core side over a valid/ready handshake.
- Sequences one or two RAM accesses, waits for data_ready on each, and returns one response per request.
- Bounds each access with a timeout so a silent RAM cannot hang the core.

---
 rtl/test_ram_master.sv | 218 +++++++++++++++++++++
 tb/tb_test_ram_master.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/test_ram_master.sv
// test_ram_master: bus initiator for the test_ram responder port.
// Turns one CPU-side byte or 16-bit little-endian request into one or two
// RAM accesses. It waits for ram_data_ready on each access and returns
// exactly one response per request. Each access is bounded by a wait
// counter, so a RAM that never answers produces an error response instead
// of hanging the core.
module test_ram_master #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic                    req_wide,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic                    resp_valid,
    output logic [2*DATA_WIDTH-1:0] resp_rdata,
    output logic                    resp_err,
    output logic                    ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_data_in,
    input  logic [DATA_WIDTH-1:0]   ram_data_out,
    input  logic                    ram_data_ready
);

    // Wait counter only has to reach TIMEOUT_CYCLES-1 before the abort edge.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] WAIT_ZERO = CW'(1'b0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Control state and captured request
    state_t                  state_q,   state_d;
    logic                    wr_q,      wr_d;
    logic                    wide_q,    wide_d;
    logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
    logic [2*DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [DATA_WIDTH-1:0]   lo_q,      lo_d;
    logic [DATA_WIDTH-1:0]   hi_q,      hi_d;
    logic [CW-1:0]           wait_q,    wait_d;
    logic                    timeout_s;

    // Registered outputs
    logic                    ram_we_q,      ram_we_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q,    ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_data_in_q, ram_data_in_d;
    logic                    resp_valid_q,  resp_valid_d;
    logic [2*DATA_WIDTH-1:0] resp_rdata_q,  resp_rdata_d;
    logic                    resp_err_q,    resp_err_d;

    // Next state, request capture, read-byte capture and wait counting
    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        wide_d    = wide_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        wait_d    = wait_q;
        timeout_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    wide_d  = req_wide;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    // Bytes that are never captured must read back as zero.
                    lo_d    = {DATA_WIDTH{1'b0}};
                    hi_d    = {DATA_WIDTH{1'b0}};
                    wait_d  = WAIT_ZERO;
                    state_d = ST_LO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LO: begin
                // A ready on the timeout edge still counts as completion.
                if (ram_data_ready) begin
                    if (!wr_q) begin
                        lo_d = ram_data_out;
                    end else begin
                        lo_d = lo_q;
                    end
                    if (wide_q) begin
                        wait_d  = WAIT_ZERO;
                        state_d = ST_HI;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    timeout_s = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            ST_HI: begin
                if (ram_data_ready) begin
                    if (!wr_q) begin
                        hi_d = ram_data_out;
                    end else begin
                        hi_d = hi_q;
                    end
                    state_d = ST_RESP;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_s = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            ST_RESP: begin
                // No accept here; the earliest new accept is in the next cycle.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the cycle that the next state describes
    always_comb begin
        ram_we_d      = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_data_in_d = ram_data_in_q;
        resp_valid_d  = 1'b0;
        resp_rdata_d  = resp_rdata_q;
        resp_err_d    = resp_err_q;

        case (state_d)
            ST_LO: begin
                ram_we_d      = wr_d;
                ram_addr_d    = addr_d;
                ram_data_in_d = wdata_d[DATA_WIDTH-1:0];
                resp_err_d    = 1'b0;
            end
            ST_HI: begin
                ram_we_d      = wr_d;
                // Address wraps modulo 2^ADDR_WIDTH.
                ram_addr_d    = addr_d + ADDR_WIDTH'(1'b1);
                ram_data_in_d = wdata_d[2*DATA_WIDTH-1:DATA_WIDTH];
                resp_err_d    = 1'b0;
            end
            ST_RESP: begin
                resp_valid_d = 1'b1;
                resp_err_d   = timeout_s;
                if (wr_d) begin
                    resp_rdata_d = {(2*DATA_WIDTH){1'b0}};
                end else begin
                    resp_rdata_d = {hi_d, lo_d};
                end
            end
            default: begin
                ram_we_d = 1'b0;
            end
        endcase
    end

    // State, capture and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            wr_q          <= 1'b0;
            wide_q        <= 1'b0;
            addr_q        <= {ADDR_WIDTH{1'b0}};
            wdata_q       <= {(2*DATA_WIDTH){1'b0}};
            lo_q          <= {DATA_WIDTH{1'b0}};
            hi_q          <= {DATA_WIDTH{1'b0}};
            wait_q        <= WAIT_ZERO;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= {ADDR_WIDTH{1'b0}};
            ram_data_in_q <= {DATA_WIDTH{1'b0}};
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= {(2*DATA_WIDTH){1'b0}};
            resp_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_q          <= wr_d;
            wide_q        <= wide_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            lo_q          <= lo_d;
            hi_q          <= hi_d;
            wait_q        <= wait_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_in_q <= ram_data_in_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
        end
    end

    // Ready is gated by reset so it reads low for the whole reset window.
    assign req_ready   = rst & (state_q == ST_IDLE);
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_data_in = ram_data_in_q;

endmodule

// File: tb/tb_test_ram_master.sv
// tb_test_ram_master: directed bench with a RAM responder model, a
// reference memory and per-cycle expected outputs derived from the access
// schedule (one access per beat, waits, timeout, wrap, reset).
module tb_test_ram_master;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TO = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid, req_write, req_wide;
    logic [AW-1:0]   req_addr;
    logic [2*DW-1:0] req_wdata;
    logic            req_ready, resp_valid, resp_err;
    logic [2*DW-1:0] resp_rdata;
    logic            ram_we, ram_data_ready;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_data_in, ram_data_out;

    always #5 clk = ~clk;

    test_ram_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_wide(req_wide), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out), .ram_data_ready(ram_data_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Unwritten locations hold a fixed address-derived pattern.
    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // RAM responder model driven by the DUT
    bit [7:0] ram_mem [0:65535];
    bit       ram_wr  [0:65535];
    assign ram_data_out = ram_wr[ram_addr] ? ram_mem[ram_addr] : pat(ram_addr);

    always @(posedge clk) begin
        if (rst && ram_we && ram_data_ready) begin
            ram_mem[ram_addr] <= ram_data_in;
            ram_wr[ram_addr]  <= 1'b1;
        end
    end

    // Reference memory maintained by the request model
    bit [7:0] ref_mem [0:65535];
    bit       ref_wr  [0:65535];

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        return ref_wr[a] ? ref_mem[a] : pat(a);
    endfunction

    // Expected outputs for the current cycle
    logic            exp_ready, exp_rv, exp_err, exp_we;
    logic [2*DW-1:0] exp_rdata;
    logic [AW-1:0]   exp_addr;
    logic [DW-1:0]   exp_din;
    bit              chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, want, $time);
        end
    endtask

    // Single compare process, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready",   32'(req_ready),   32'(exp_ready));
            chk("resp_valid",  32'(resp_valid),  32'(exp_rv));
            chk("resp_err",    32'(resp_err),    32'(exp_err));
            chk("resp_rdata",  32'(resp_rdata),  32'(exp_rdata));
            chk("ram_we",      32'(ram_we),      32'(exp_we));
            chk("ram_addr",    32'(ram_addr),    32'(exp_addr));
            chk("ram_data_in", 32'(ram_data_in), 32'(exp_din));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reset_exp();
        exp_ready = 1'b0; exp_rv = 1'b0; exp_err = 1'b0; exp_we = 1'b0;
        exp_rdata = 16'h0000; exp_addr = 16'h0000; exp_din = 8'h00;
    endtask

    // One RAM access: ready low for w cycles, then high; abort after TO empty edges.
    task automatic run_phase(input bit wr, input logic [15:0] a, input logic [7:0] d,
                             input int w, output bit ok);
        ok = 1'b0;
        exp_addr = a; exp_din = d; exp_we = wr;
        for (int k = 0; k < TO; k++) begin
            ram_data_ready = (k == w);
            tick();
            if (k == w) begin
                ok = 1'b1;
                break;
            end
        end
        ram_data_ready = 1'b0;
    endtask

    // Full request from the idle cycle through the response cycle.
    task automatic do_req(input bit wr, input bit wide, input logic [15:0] a,
                          input logic [15:0] wd, input int wlo, input int whi,
                          input bit keep_valid, output logic [15:0] rd, output bit err);
        logic [7:0] lo, hi;
        bit ok;
        lo = 8'h00; hi = 8'h00; err = 1'b0;
        req_valid = 1'b1; req_write = wr; req_wide = wide; req_addr = a; req_wdata = wd;
        ram_data_ready = 1'b0;
        exp_ready = 1'b1; exp_rv = 1'b0; exp_we = 1'b0;
        tick();
        if (!keep_valid) req_valid = 1'b0;
        exp_ready = 1'b0; exp_err = 1'b0;
        run_phase(wr, a, wd[7:0], wlo, ok);
        if (ok) begin
            if (wr) begin ref_mem[a] = wd[7:0]; ref_wr[a] = 1'b1; end
            else lo = ref_rd(a);
        end else begin
            err = 1'b1;
        end
        if (wide && ok) begin
            run_phase(wr, a + 16'd1, wd[15:8], whi, ok);
            if (ok) begin
                if (wr) begin ref_mem[a + 16'd1] = wd[15:8]; ref_wr[a + 16'd1] = 1'b1; end
                else hi = ref_rd(a + 16'd1);
            end else begin
                err = 1'b1;
            end
        end
        exp_we = 1'b0; exp_rv = 1'b1; exp_err = err;
        exp_rdata = wr ? 16'h0000 : {hi, lo};
        rd = exp_rdata;
        ram_data_ready = 1'b1;
        tick();
        ram_data_ready = 1'b0;
        exp_rv = 1'b0; exp_ready = 1'b1;
    endtask

    logic [15:0] rd;
    bit          er;

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_wide = 1'b0;
        req_addr = 16'h0000; req_wdata = 16'h0000; ram_data_ready = 1'b0;
        set_reset_exp();
        chk_en = 1'b1;
        repeat (3) tick();
        rst = 1'b1; exp_ready = 1'b1;
        tick();

        // Byte write, zero waits
        do_req(1'b1, 1'b0, 16'h0040, 16'h0012, 0, 0, 1'b0, rd, er);
        chk("pin_w1_err", 32'(er), 32'h0);
        // Byte read with three wait cycles
        do_req(1'b0, 1'b0, 16'h0040, 16'hC3C3, 3, 0, 1'b0, rd, er);
        chk("pin_r1_data", 32'(rd), 32'h0012);
        // Wide write across the address wrap
        do_req(1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 0, 0, 1'b0, rd, er);
        chk("pin_mem_ffff", 32'(ram_mem[16'hFFFF]), 32'hEF);
        chk("pin_mem_0000", 32'(ram_mem[16'h0000]), 32'hBE);
        do_req(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1, 2, 1'b0, rd, er);
        chk("pin_wide_rd", 32'(rd), 32'hBEEF);
        // Timeout on a byte read, then ready arriving on the timeout edge
        do_req(1'b0, 1'b0, 16'h0040, 16'h0000, 100, 0, 1'b0, rd, er);
        chk("pin_to_err", 32'(er), 32'h1);
        chk("pin_to_data", 32'(rd), 32'h0000);
        do_req(1'b0, 1'b0, 16'h0040, 16'h0000, TO - 1, 0, 1'b0, rd, er);
        chk("pin_edge_err", 32'(er), 32'h0);
        chk("pin_edge_data", 32'(rd), 32'h0012);
        // Timeout in the high beat of a read and of a write
        do_req(1'b0, 1'b1, 16'h0040, 16'h0000, 0, TO, 1'b0, rd, er);
        chk("pin_hito_rd", 32'(rd), 32'h0012);
        do_req(1'b1, 1'b1, 16'h0300, 16'hA1B2, 0, TO, 1'b0, rd, er);
        chk("pin_hito_werr", 32'(er), 32'h1);
        do_req(1'b0, 1'b1, 16'h0300, 16'h0000, 0, 0, 1'b0, rd, er);
        chk("pin_partial", 32'(rd), 32'h58B2);

        // Reset asserted during the high beat of a wide write
        req_valid = 1'b1; req_write = 1'b1; req_wide = 1'b1;
        req_addr = 16'h0100; req_wdata = 16'h3344; exp_ready = 1'b1;
        tick();
        req_valid = 1'b0; exp_ready = 1'b0; exp_err = 1'b0;
        run_phase(1'b1, 16'h0100, 8'h44, 0, er);
        ref_mem[16'h0100] = 8'h44; ref_wr[16'h0100] = 1'b1;
        exp_addr = 16'h0101; exp_din = 8'h33; exp_we = 1'b1;
        tick();
        rst = 1'b0;
        set_reset_exp();
        tick();
        tick();
        rst = 1'b1; exp_ready = 1'b1;
        tick();
        do_req(1'b0, 1'b0, 16'h0040, 16'h0000, 0, 0, 1'b0, rd, er);
        chk("pin_post_rst", 32'(rd), 32'h0012);
        do_req(1'b0, 1'b1, 16'h0100, 16'h0000, 2, 0, 1'b0, rd, er);
        chk("pin_rst_partial", 32'(rd), 32'h5A44);

        // Back-to-back with req_valid held high
        do_req(1'b1, 1'b0, 16'h0200, 16'hAB77, 1, 0, 1'b1, rd, er);
        do_req(1'b0, 1'b1, 16'h0200, 16'h0000, 0, 0, 1'b0, rd, er);
        chk("pin_b2b", 32'(rd), 32'h5977);

        tick();
        tick();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
